// File: rtl/tone_pkg.sv
// tone_pkg: shared state encoding, divider sizing and defaults for the square tone generator.
package tone_pkg;

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    localparam int FREQ_W        = 16;
    localparam int DEF_CLK_HZ    = 50000000;
    localparam int DEF_AMPLITUDE = 10000000;

    // Quotient bits needed so that CLK_HZ/2 (the 1 Hz half-period) still fits.
    function automatic int div_steps(input int clk_hz);
        return $clog2(clk_hz / 2 + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, abortable via clear.
module seq_divider #(
    parameter int W  = 25,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [W-1:0]  quotient
);
    localparam int CW = $clog2(W + 1);

    logic [DW-1:0] d, rem, src_rem, src_d, next_rem;
    logic [W-1:0]  q, src_q, next_q;
    logic [DW:0]   shifted;
    logic [CW-1:0] cnt;
    logic          active, fits;

    // The first step runs on the start edge itself so the whole job takes exactly W edges.
    always_comb begin
        src_rem  = start ? '0 : rem;
        src_q    = start ? dividend : q;
        src_d    = start ? divisor : d;
        shifted  = {src_rem, src_q[W-1]};
        fits     = shifted >= {1'b0, src_d};
        next_rem = fits ? shifted[DW-1:0] - src_d : shifted[DW-1:0];
        next_q   = {src_q[W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            active <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            q      <= '0;
            d      <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= CW'(W - 1);
            rem    <= next_rem;
            q      <= next_q;
            d      <= divisor;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
                rem <= next_rem;
                q   <= next_q;
            end
        end
    end

    assign done     = active && cnt == '0;
    assign quotient = q;

endmodule

// File: rtl/square_tone_gen.sv
// square_tone_gen: gated square-wave sample source whose half-period is CLK_HZ/2 divided by the tone frequency.
module square_tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int AMPLITUDE = DEF_AMPLITUDE,
    parameter int SAMPLE_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FREQ_W-1:0]          frequency,
    input  logic                       note_on,
    input  logic                       sample_ready,
    output logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       busy
);
    localparam int                          STEPS    = div_steps(CLK_HZ);
    localparam logic [STEPS-1:0]            DIVIDEND = STEPS'(CLK_HZ / 2);
    localparam logic signed [SAMPLE_W-1:0]  POS      = SAMPLE_W'(AMPLITUDE);
    localparam logic signed [SAMPLE_W-1:0]  NEG      = -POS;

    state_t                      state;
    logic                        level, gate_off, start, abort, wrap, div_done;
    logic [STEPS-1:0]            half_period, counter, quotient;
    logic [FREQ_W-1:0]           freq_latched;
    logic signed [SAMPLE_W-1:0]  source;

    always_comb begin
        gate_off = !note_on || frequency == '0;
        start    = !gate_off && (state == IDLE || (state == RUN && frequency != freq_latched));
        abort    = state == DIV && !note_on;
        wrap     = counter == half_period - 1'b1;
        source   = state == IDLE ? '0 : level ? POS : NEG;
    end

    seq_divider #(.W(STEPS), .DW(FREQ_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (abort),
        .start    (start),
        .dividend (DIVIDEND),
        .divisor  (frequency),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
            level        <= 1'b0;
            half_period  <= '0;
            counter      <= '0;
            freq_latched <= '0;
        end else begin
            sample_valid <= 1'b1;
            if (!sample_valid || sample_ready)
                sample <= source;
            if (start)
                freq_latched <= frequency;
            unique case (state)
                IDLE: if (start) begin
                    state <= DIV;
                    busy  <= 1'b1;
                end
                DIV: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    level <= 1'b0;
                end else if (div_done) begin
                    state       <= RUN;
                    busy        <= 1'b0;
                    half_period <= quotient == '0 ? STEPS'(1) : quotient;
                    counter     <= '0;
                end
                RUN: begin
                    counter <= wrap ? '0 : counter + 1'b1;
                    if (wrap)
                        level <= ~level;
                    if (gate_off) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else if (start) begin
                        state <= DIV;
                        busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_tone_gen.sv
// tb_square_tone_gen: randomized and directed stimulus checked cycle by cycle against a behavioural tone model.
module tb_square_tone_gen;
    localparam int CLK_HZ = 8800;
    localparam int AMP    = 100;
    localparam int HALF   = CLK_HZ / 2;
    localparam int STEPS  = $clog2(HALF + 1);

    logic               clk = 1'b0, reset = 1'b1, note_on = 1'b0, sample_ready = 1'b1;
    logic [15:0]        frequency = '0;
    logic               sample_valid, busy;
    logic signed [31:0] sample;

    always #5 clk = ~clk;

    square_tone_gen #(.CLK_HZ(CLK_HZ), .AMPLITUDE(AMP), .SAMPLE_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .frequency    (frequency),
        .note_on      (note_on),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample       (sample),
        .busy         (busy)
    );

    int tests = 0, errors = 0;
    // Model: mode 0 silent, 1 computing, 2 playing; hp is the half-period in cycles.
    int m_mode, m_left, m_fl, m_hp, m_cnt, m_lvl, m_valid, m_smp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, $signed(got), $signed(exp));
        end
    endtask

    task automatic model_step();
        int src;
        if (reset) begin
            m_mode = 0; m_left = 0; m_fl = 0; m_hp = 0;
            m_cnt = 0; m_lvl = 0; m_valid = 0; m_smp = 0;
        end else begin
            src = m_mode == 0 ? 0 : (m_lvl != 0 ? AMP : -AMP);
            if (m_valid == 0 || sample_ready) m_smp = src;
            m_valid = 1;
            if (m_mode == 0) begin
                if (note_on && frequency != 0) begin
                    m_fl = frequency; m_mode = 1; m_left = STEPS;
                end
            end else if (m_mode == 1) begin
                if (!note_on) begin
                    m_mode = 0; m_lvl = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hp = HALF / m_fl;
                        if (m_hp == 0) m_hp = 1;
                        m_cnt = 0; m_mode = 2;
                    end
                end
            end else begin
                m_cnt++;
                if (m_cnt == m_hp) begin
                    m_cnt = 0; m_lvl = 1 - m_lvl;
                end
                if (!note_on || frequency == 0) begin
                    m_mode = 0; m_lvl = 0;
                end else if (frequency != m_fl) begin
                    m_fl = frequency; m_mode = 1; m_left = STEPS;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("sample_valid", 32'(sample_valid), 32'(m_valid));
        check("sample", sample, m_smp);
        check("busy", 32'(busy), 32'(m_mode == 1));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [15:0] pick_freq();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'd0;
        if (r == 1) return 16'($urandom_range(5000, 65000));
        if (r == 2) return 16'($urandom_range(2200, 4400));
        return 16'($urandom_range(100, 1500));
    endfunction

    initial begin
        note_on = 1'b1; frequency = 16'd440;
        run(3);
        reset = 1'b0;
        run(60);
        sample_ready = 1'b0;
        run(25);
        sample_ready = 1'b1;
        run(10);
        frequency = 16'd220;
        run(80);
        note_on = 1'b0;
        run(5);
        note_on = 1'b1; frequency = 16'd440;
        run(5);
        note_on = 1'b0;
        run(5);
        note_on = 1'b1; frequency = 16'd0;
        run(10);
        frequency = 16'd440;
        run(40);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(40);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) frequency = pick_freq();
            if ($urandom_range(0, 59) == 0) note_on = ~note_on;
            sample_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 299) == 0;
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
